gate_stim_checker: RTL and testbench
====================================

Name: gate_stim_checker

Overview:
Self-running stimulus and response stage that wraps the mux-based logic-gate block.
- Upstream role: drives the gate block's A and B inputs through all four input combinations.
- Downstream role: captures the seven gate outputs and compares them against a golden truth table.
- Reports per-gate sticky failures, a mismatch count, and a pass/done status.
- Used for on-chip self-test of the gate block, replacing the hand-written stimulus sequence.

Parameters:
SETTLE_CYCLES, 2, cycles each vector is held before sampling; legal range 1..255.
REPEAT, 1, number of full 4-vector passes per run; legal range 1..255.
ERR_W, 8, width of the mismatch counter.

Ports:
clk  in  1  clock, all state on rising edge
rst_n  in  1  asynchronous active-low reset
start  in  1  level-sampled run request
A  out  1  stimulus to gate block input A
B  out  1  stimulus to gate block input B
notout  in  1  observed NOT(A)
andout  in  1  observed A AND B
orout  in  1  observed A OR B
xorout  in  1  observed A XOR B
xnorout  in  1  observed A XNOR B
nandout  in  1  observed A NAND B
norout  in  1  observed A NOR B
busy  out  1  run in progress
done  out  1  run complete, held until next accepted start
pass  out  1  done and zero mismatches
err_count  out  ERR_W  mismatching vectors, saturating
fail_vec  out  7  sticky per-gate mismatch flags
vec_idx  out  2  current vector index, {A,B}

Behaviour:
- Reset: one clock; reset is asynchronous and active-low (ports clk, rst_n). On reset assertion all outputs go to 0 (A, B, busy, done, pass, err_count, fail_vec, vec_idx) and state goes to IDLE. Reset mid-run aborts the run immediately; nothing is retained.
- Observed vector bit order, bit0..bit6: not, and, or, xor, xnor, nand, nor.
- Golden vector: ~A, A&B, A|B, A^B, ~(A^B), ~(A&B), ~(A|B), computed from the registered A/B.
- Stimulus mapping: A = vec_idx[1], B = vec_idx[0]; order is 00, 01, 10, 11.
- States: IDLE, SETTLE, SAMPLE, DONE.
- IDLE or DONE, start=1:
  - Next cycle enters SETTLE.
  - vec_idx=0, pass counter=0, err_count=0, fail_vec=0.
  - busy=1, done=0, pass=0.
- start while busy is ignored.
- SETTLE: holds for exactly SETTLE_CYCLES cycles, then goes to SAMPLE.
- SAMPLE (one cycle):
  - Compare observed vs golden.
  - On any mismatch: OR the mismatching bits into fail_vec and increment err_count by 1 (one count per vector, not per bit).
  - err_count saturates at all-ones.
- Leaving SAMPLE:
  - If vec_idx==3 and pass counter==REPEAT-1: go to DONE.
  - Otherwise: advance vec_idx (wraps 3 to 0, pass counter increments on wrap) and return to SETTLE. A and B update on the same edge.
- Cycles per vector = SETTLE_CYCLES+1. Run length = 4·REPEAT·(SETTLE_CYCLES+1) cycles from the start-accept edge to done=1.
- DONE:
  - busy=0, done=1.
  - pass=1 iff err_count==0.
  - A, B, vec_idx hold their last values.
  - start with start=1 continuously held restarts a run every time DONE is reached.

Optional Feature:
GATE_CHK_STOP_ON_FAIL_EN.
- Defined: the first SAMPLE with a mismatch transitions directly to DONE. err_count=1, fail_vec holds only that vector's failing bits, vec_idx and A/B freeze on the failing vector.
- Undefined: a full run always completes as described above.

Decomposition:
- Package gate_chk_pkg:
  - state enum.
  - Bit-index constants for the seven gates.
  - NUM_GATES=7, NUM_VEC=4.
- One sub-module, gate_golden: combinational A,B to 7-bit expected vector, reused by the bench scoreboard.

Test Plan:
1. Correct gate block, defaults, start pulse -> A/B sequence 00,01,10,11, each held 3 cycles; done=1 exactly 12 cycles after accept; err_count=0, pass=1, fail_vec=0.
2. andout forced stuck-at-0 -> err_count=1 (vector 11 only), fail_vec=7'b0000010, pass=0.
3. xorout inverted, REPEAT=3 -> err_count=12, fail_vec=7'b0001000, done after 36 cycles.
4. All outputs inverted, ERR_W=2 -> err_count saturates at 3, fail_vec=7'b1111111.
5. Start re-pulsed mid-run is ignored (run length unchanged). rst_n low at cycle 5 -> all outputs 0 asynchronously; a new start after release runs cleanly.
6. GATE_CHK_STOP_ON_FAIL_EN defined, norout stuck-at-1 -> done after 3 cycles on vector 00, err_count=0? no: vector 00 expects nor=1, so passes; first failure is at vector 01 -> done 6 cycles after accept, vec_idx=1, err_count=1, fail_vec=7'b1000000.

Source files
------------

// File: rtl/gate_chk_pkg.sv
// Shared types and constants for the gate block self-test stage.
// Gate bit order in every 7-bit vector: not, and, or, xor, xnor, nand, nor (bit0..bit6).
package gate_chk_pkg;

    localparam int NUM_GATES = 7;
    localparam int NUM_VEC   = 4;

    localparam int G_NOT  = 0;
    localparam int G_AND  = 1;
    localparam int G_OR   = 2;
    localparam int G_XOR  = 3;
    localparam int G_XNOR = 4;
    localparam int G_NAND = 5;
    localparam int G_NOR  = 6;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SETTLE,
        ST_SAMPLE,
        ST_DONE
    } state_t;

    typedef logic [NUM_GATES-1:0] gate_vec_t;

endpackage

// File: rtl/gate_golden.sv
// Golden truth table for the seven gates driven by one A/B pair.
// Latency: combinational.
// Backpressure: none.
module gate_golden
    import gate_chk_pkg::*;
(
    input  logic      a,
    input  logic      b,
    output gate_vec_t expected
);

    always_comb begin
        expected         = '0;
        expected[G_NOT]  = ~a;
        expected[G_AND]  = a & b;
        expected[G_OR]   = a | b;
        expected[G_XOR]  = a ^ b;
        expected[G_XNOR] = ~(a ^ b);
        expected[G_NAND] = ~(a & b);
        expected[G_NOR]  = ~(a | b);
    end

endmodule

// File: rtl/gate_stim_checker.sv
// Self-running stimulus/response checker for the mux-based gate block; GATE_CHK_STOP_ON_FAIL_EN ends a run on first mismatch.
// Latency: SETTLE_CYCLES+1 cycles per vector, 4*REPEAT*(SETTLE_CYCLES+1) from start accept to done.
// Backpressure: none; start is level-sampled only in IDLE/DONE and ignored while busy.
module gate_stim_checker
    import gate_chk_pkg::*;
#(
    parameter int SETTLE_CYCLES = 2,
    parameter int REPEAT        = 1,
    parameter int ERR_W         = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    output logic             A,
    output logic             B,
    input  logic             notout,
    input  logic             andout,
    input  logic             orout,
    input  logic             xorout,
    input  logic             xnorout,
    input  logic             nandout,
    input  logic             norout,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [ERR_W-1:0] err_count,
    output logic [6:0]       fail_vec,
    output logic [1:0]       vec_idx
);

    localparam logic [7:0] SETTLE_LAST = 8'(SETTLE_CYCLES - 1);
    localparam logic [7:0] REPEAT_LAST = 8'(REPEAT - 1);

`ifdef GATE_CHK_STOP_ON_FAIL_EN
    localparam bit STOP_ON_FAIL = 1'b1;
`else
    localparam bit STOP_ON_FAIL = 1'b0;
`endif

    state_t     state;
    logic [7:0] settle_cnt;
    logic [7:0] pass_cnt;

    gate_vec_t  golden;
    gate_vec_t  observed;
    gate_vec_t  mism;
    logic       any_mism;
    logic       last_vec;
    logic [ERR_W-1:0] err_next;

    // Stimulus is taken straight from the registered vector index.
    assign A = vec_idx[1];
    assign B = vec_idx[0];

    gate_golden u_golden (
        .a        (A),
        .b        (B),
        .expected (golden)
    );

    always_comb begin
        observed         = '0;
        observed[G_NOT]  = notout;
        observed[G_AND]  = andout;
        observed[G_OR]   = orout;
        observed[G_XOR]  = xorout;
        observed[G_XNOR] = xnorout;
        observed[G_NAND] = nandout;
        observed[G_NOR]  = norout;
    end

    assign mism     = observed ^ golden;
    assign any_mism = |mism;
    assign last_vec = (vec_idx == 2'd3) && (pass_cnt == REPEAT_LAST);
    assign err_next = (err_count == '1) ? err_count : err_count + 1'b1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ST_IDLE;
            settle_cnt <= '0;
            pass_cnt   <= '0;
            vec_idx    <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
            pass       <= 1'b0;
            err_count  <= '0;
            fail_vec   <= '0;
        end else begin
            case (state)
                ST_IDLE, ST_DONE: begin
                    if (start) begin
                        state      <= ST_SETTLE;
                        settle_cnt <= '0;
                        pass_cnt   <= '0;
                        vec_idx    <= '0;
                        err_count  <= '0;
                        fail_vec   <= '0;
                        busy       <= 1'b1;
                        done       <= 1'b0;
                        pass       <= 1'b0;
                    end
                end
                ST_SETTLE: begin
                    if (settle_cnt == SETTLE_LAST) begin
                        state <= ST_SAMPLE;
                    end else begin
                        settle_cnt <= settle_cnt + 8'd1;
                    end
                end
                ST_SAMPLE: begin
                    settle_cnt <= '0;
                    if (any_mism) begin
                        fail_vec  <= fail_vec | mism;
                        err_count <= err_next;
                    end
                    // pass looks at the pre-update count plus this sample's result.
                    if (last_vec || (STOP_ON_FAIL && any_mism)) begin
                        state <= ST_DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        pass  <= (err_count == '0) && !any_mism;
                    end else begin
                        state   <= ST_SETTLE;
                        vec_idx <= vec_idx + 2'd1;
                        if (vec_idx == 2'd3) begin
                            pass_cnt <= pass_cnt + 8'd1;
                        end
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_gate_stim_checker.sv
// Scoreboard bench: three checker instances with different parameters, each wrapped around a faultable gate model.
module tb_gate_stim_checker;

    localparam int ND = 3;
    localparam int SC [ND] = '{2, 2, 1};
    localparam int RP [ND] = '{1, 3, 3};
    localparam int EW [ND] = '{8, 8, 2};

    typedef struct {
        int err;
        int fv;
        int pass;
        int vidx;
        int cyc;
    } exp_t;

    logic       clk;
    logic       rst_n;
    logic       start;
    logic [6:0] f0_m;
    logic [6:0] f1_m;
    logic [6:0] inv_m;

    logic       a_s    [ND];
    logic       b_s    [ND];
    logic       busy_s [ND];
    logic       done_s [ND];
    logic       pass_s [ND];
    logic [7:0] errc   [ND];
    logic [6:0] fv_s   [ND];
    logic [1:0] vidx_s [ND];
    logic [6:0] obs    [ND];

    exp_t q [ND][$];
    bit   running [ND];
    bit   busy_q  [ND];
    bit   done_q  [ND];
    int   cyc     [ND];

    int checks;
    int errors;
    bit fin_req;
    bit fin_ack;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    for (genvar g = 0; g < ND; g++) begin : g_dut
        localparam int W = EW[g];
        logic [W-1:0] ec;
        logic [6:0]   ideal;

        assign ideal = {~(a_s[g] | b_s[g]), ~(a_s[g] & b_s[g]), ~(a_s[g] ^ b_s[g]),
                        a_s[g] ^ b_s[g], a_s[g] | b_s[g], a_s[g] & b_s[g], ~a_s[g]};
        assign obs[g]  = ((ideal ^ inv_m) & ~f0_m) | f1_m;
        assign errc[g] = 8'(ec);

        gate_stim_checker #(
            .SETTLE_CYCLES (SC[g]),
            .REPEAT        (RP[g]),
            .ERR_W         (W)
        ) u_dut (
            .clk       (clk),
            .rst_n     (rst_n),
            .start     (start),
            .A         (a_s[g]),
            .B         (b_s[g]),
            .notout    (obs[g][0]),
            .andout    (obs[g][1]),
            .orout     (obs[g][2]),
            .xorout    (obs[g][3]),
            .xnorout   (obs[g][4]),
            .nandout   (obs[g][5]),
            .norout    (obs[g][6]),
            .busy      (busy_s[g]),
            .done      (done_s[g]),
            .pass      (pass_s[g]),
            .err_count (ec),
            .fail_vec  (fv_s[g]),
            .vec_idx   (vidx_s[g])
        );
    end

    task automatic chk(input string nm, input int g, input int got, input int expv);
        checks++;
        if (got != expv) begin
            errors++;
            $display("FAIL %s dut%0d: got %0d, expected %0d", nm, g, got, expv);
        end
    endtask

    // Hand-computed results. dut0: S=2 R=1 (12 cyc), dut1: S=2 R=3 (36), dut2: S=1 R=3 W=2 (24).
    // Tests: 0 good, 1 and stuck-0, 2 xor inverted, 3 all inverted, 4 nor stuck-1.
    function automatic exp_t exp_of(input int t, input int d);
        exp_t e;
        e.err  = 0;
        e.fv   = 0;
        e.vidx = 3;
        e.cyc  = (d == 0) ? 12 : (d == 1) ? 36 : 24;
`ifdef GATE_CHK_STOP_ON_FAIL_EN
        case (t)
            1: begin e.fv = 7'h02; e.err = 1; e.cyc = (d == 2) ? 8 : 12; end
            2: begin e.fv = 7'h08; e.err = 1; e.vidx = 0; e.cyc = (d == 2) ? 2 : 3; end
            3: begin e.fv = 7'h7f; e.err = 1; e.vidx = 0; e.cyc = (d == 2) ? 2 : 3; end
            4: begin e.fv = 7'h40; e.err = 1; e.vidx = 1; e.cyc = (d == 2) ? 4 : 6; end
            default: ;
        endcase
`else
        case (t)
            1: begin e.fv = 7'h02; e.err = (d == 0) ? 1 : 3; end
            2: begin e.fv = 7'h08; e.err = (d == 0) ? 4 : (d == 1) ? 12 : 3; end
            3: begin e.fv = 7'h7f; e.err = (d == 0) ? 4 : (d == 1) ? 12 : 3; end
            4: begin e.fv = 7'h40; e.err = (d == 0) ? 3 : (d == 1) ? 9 : 3; end
            default: ;
        endcase
`endif
        e.pass = (e.err == 0) ? 1 : 0;
        return e;
    endfunction

    // Monitor: reset-state checks, per-cycle stimulus checks, and result checks on done.
    always @(negedge clk) begin
        int   ev;
        exp_t e;
        for (int g = 0; g < ND; g++) begin
            if (!rst_n) begin
                chk("reset_outputs", g,
                    int'({a_s[g], b_s[g], busy_s[g], done_s[g], pass_s[g], errc[g], fv_s[g], vidx_s[g]}), 0);
                q[g].delete();
                running[g] = 1'b0;
            end else begin
                if (busy_s[g] && !busy_q[g]) begin
                    running[g] = 1'b1;
                    cyc[g]     = 0;
                end else if (running[g]) begin
                    cyc[g]++;
                end
                if (running[g] && !done_s[g]) begin
                    ev = (cyc[g] / (SC[g] + 1)) % 4;
                    chk("stim_ab", g, int'({a_s[g], b_s[g]}), ev);
                    chk("vec_idx_run", g, int'(vidx_s[g]), ev);
                    if (cyc[g] > 100) begin
                        chk("run_timeout", g, cyc[g], 100);
                        running[g] = 1'b0;
                    end
                end
                if (done_s[g] && !done_q[g]) begin
                    if (!running[g] || q[g].size() == 0) begin
                        chk("unexpected_done", g, 1, 0);
                    end else begin
                        e = q[g].pop_front();
                        chk("run_cycles", g, cyc[g], e.cyc);
                        chk("err_count", g, int'(errc[g]), e.err);
                        chk("fail_vec", g, int'(fv_s[g]), e.fv);
                        chk("pass", g, int'(pass_s[g]), e.pass);
                        chk("vec_idx_done", g, int'(vidx_s[g]), e.vidx);
                        chk("busy_done", g, int'(busy_s[g]), 0);
                    end
                    running[g] = 1'b0;
                end
            end
            busy_q[g] = busy_s[g];
            done_q[g] = done_s[g];
        end
        if (fin_req && !fin_ack) begin
            for (int g = 0; g < ND; g++) begin
                chk("pending_results", g, q[g].size(), 0);
            end
            fin_ack = 1'b1;
        end
    end

    task automatic set_fault(input int t);
        f0_m  = (t == 1) ? 7'h02 : 7'h00;
        f1_m  = (t == 4) ? 7'h40 : 7'h00;
        inv_m = (t == 2) ? 7'h08 : (t == 3) ? 7'h7f : 7'h00;
    endtask

    task automatic wait_all_done();
        bit all;
        for (int i = 0; i < 150; i++) begin
            @(negedge clk);
            all = 1'b1;
            for (int g = 0; g < ND; g++) all = all & done_s[g];
            if (all) break;
        end
        @(negedge clk);
    endtask

    task automatic run_test(input int t, input bit repulse);
        set_fault(t);
        for (int g = 0; g < ND; g++) q[g].push_back(exp_of(t, g));
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        if (repulse) begin
            repeat (3) @(negedge clk);
            start = 1'b1;
            @(negedge clk);
            start = 1'b0;
        end
        wait_all_done();
    endtask

    initial begin
        checks  = 0;
        errors  = 0;
        fin_req = 1'b0;
        fin_ack = 1'b0;
        rst_n   = 1'b0;
        start   = 1'b0;
        set_fault(0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        for (int t = 0; t < 5; t++) run_test(t, 1'b0);
        run_test(0, 1'b1);

        // Abort a run with an asynchronous reset between clock edges, then rerun cleanly.
        set_fault(0);
        for (int g = 0; g < ND; g++) q[g].push_back(exp_of(0, g));
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (5) @(posedge clk);
        #1 rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        run_test(0, 1'b0);
        run_test(4, 1'b0);

        fin_req = 1'b1;
        for (int i = 0; i < 10 && !fin_ack; i++) @(negedge clk);
        if (!fin_ack) begin
            errors++;
            $display("FAIL final_check: monitor did not respond, got 0 expected 1");
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
